// File: rtl/mem_burst_rd_responder.sv
// Synthesizable memory model answering single cache-line read bursts after a fixed latency.
// Holds a preloadable word array; one burst of BEAT_NUM beats per accepted request.
module mem_burst_rd_responder #(
    parameter int MEM_WORDS  = 4096,
    parameter int BEAT_NUM   = 8,
    parameter int RD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        from_cache_rd_req_valid,
    input  logic [31:0] from_cache_rd_req_addr,
    output logic        to_cache_rd_req_ready,
    output logic        to_cache_rd_rsp_valid,
    output logic [31:0] to_cache_rd_rsp_data,
    output logic        to_cache_rd_rsp_last,
    input  logic        from_cache_rd_rsp_ready,
    input  logic        init_wen,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_wdata
);

    localparam int AW    = $clog2(MEM_WORDS);
    localparam int BW    = $clog2(BEAT_NUM);
    localparam int BASEW = AW - BW;
    localparam int LW    = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_LAT   = 3'b010,
        S_BURST = 3'b100
    } state_e;

    state_e             state_q, state_d;
    logic [BASEW-1:0]   base_q, base_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [LW-1:0]      lat_q, lat_d;
    logic [31:0]        mem_q [MEM_WORDS];
    logic [AW-1:0]      rd_idx_s;
    logic [AW-1:0]      wr_idx_s;
    logic               last_s;
    logic               unused_addr_s;

    // Line base concatenated with the beat number is the word index; upper address bits alias.
    assign rd_idx_s      = {base_q, beat_q};
    assign wr_idx_s      = init_addr[AW+1:2];
    assign last_s        = (beat_q == BW'(BEAT_NUM - 1));
    assign unused_addr_s = ^{from_cache_rd_req_addr, init_addr};

    assign to_cache_rd_rsp_data = mem_q[rd_idx_s];

    // Preload write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (init_wen) begin
            mem_q[wr_idx_s] <= init_wdata;
        end
    end

    // FSM and burst bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= {BASEW{1'b0}};
            beat_q  <= {BW{1'b0}};
            lat_q   <= {LW{1'b0}};
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state logic; handshake outputs decode only the registered state.
    always_comb begin
        state_d               = state_q;
        base_d                = base_q;
        beat_d                = beat_q;
        lat_d                 = lat_q;
        to_cache_rd_req_ready = 1'b0;
        to_cache_rd_rsp_valid = 1'b0;
        to_cache_rd_rsp_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                to_cache_rd_req_ready = 1'b1;
                if (from_cache_rd_req_valid) begin
                    base_d = from_cache_rd_req_addr[AW+1:BW+2];
                    beat_d = {BW{1'b0}};
                    lat_d  = LW'(RD_LATENCY);
                    if (RD_LATENCY == 0) begin
                        state_d = S_BURST;
                    end else begin
                        state_d = S_LAT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAT: begin
                lat_d = lat_q - LW'(1);
                if (lat_q == LW'(1)) begin
                    state_d = S_BURST;
                end else begin
                    state_d = S_LAT;
                end
            end
            S_BURST: begin
                to_cache_rd_rsp_valid = 1'b1;
                to_cache_rd_rsp_last  = last_s;
                if (from_cache_rd_rsp_ready) begin
                    if (last_s) begin
                        beat_d  = {BW{1'b0}};
                        state_d = S_IDLE;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                        state_d = S_BURST;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = {BW{1'b0}};
                lat_d   = {LW{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_mem_burst_rd_responder.sv
// Directed bench: per-cycle vector table for latency-4 bursts plus hand sequences for
// held-beat preload writes and a zero-latency back-to-back instance.
module tb_mem_burst_rd_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid0;
    logic [31:0] req_addr;
    logic        rsp_ready, rsp_ready0;
    logic        init_wen;
    logic [31:0] init_addr, init_wdata;
    logic        req_ready, rsp_valid, rsp_last;
    logic [31:0] rsp_data;
    logic        req_ready0, rsp_valid0, rsp_last0;
    logic [31:0] rsp_data0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_burst_rd_responder #(.MEM_WORDS(4096), .BEAT_NUM(8), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .from_cache_rd_req_valid(req_valid), .from_cache_rd_req_addr(req_addr),
        .to_cache_rd_req_ready(req_ready), .to_cache_rd_rsp_valid(rsp_valid),
        .to_cache_rd_rsp_data(rsp_data), .to_cache_rd_rsp_last(rsp_last),
        .from_cache_rd_rsp_ready(rsp_ready),
        .init_wen(init_wen), .init_addr(init_addr), .init_wdata(init_wdata)
    );

    mem_burst_rd_responder #(.MEM_WORDS(4096), .BEAT_NUM(8), .RD_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .from_cache_rd_req_valid(req_valid0), .from_cache_rd_req_addr(req_addr),
        .to_cache_rd_req_ready(req_ready0), .to_cache_rd_rsp_valid(rsp_valid0),
        .to_cache_rd_rsp_data(rsp_data0), .to_cache_rd_rsp_last(rsp_last0),
        .from_cache_rd_rsp_ready(rsp_ready0),
        .init_wen(init_wen), .init_addr(init_addr), .init_wdata(init_wdata)
    );

    typedef struct {
        int          tid;
        logic        rst;
        logic        req_valid;
        logic [31:0] req_addr;
        logic        rsp_ready;
        logic        exp_req_ready;
        logic        exp_rsp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int idx, input logic [31:0] val);
        init_wen   = 1'b1;
        init_addr  = 32'(idx) << 2;
        init_wdata = val;
        step();
        init_wen   = 1'b0;
    endtask

    function automatic void push(input int tid, input logic r, input logic rv, input logic [31:0] a,
                                 input logic rr, input logic e_rr, input logic e_v,
                                 input logic [31:0] e_d, input logic e_l);
        vec_t v;
        v.tid = tid; v.rst = r; v.req_valid = rv; v.req_addr = a; v.rsp_ready = rr;
        v.exp_req_ready = e_rr; v.exp_rsp_valid = e_v; v.exp_data = e_d; v.exp_last = e_l;
        vecs.push_back(v);
    endfunction

    // Request cycle, LAT wait cycles, beats under a ready pattern (1s after it ends), one idle cycle.
    function automatic void add_burst(input int tid, input logic [31:0] addr, input logic [31:0] d0,
                                      input logic [15:0] pat, input int pat_len);
        int   beat;
        int   c;
        logic r;
        push(tid, 1'b0, 1'b1, addr, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < LAT; i++) push(tid, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        beat = 0;
        c    = 0;
        while (beat < 8) begin
            r = (c < pat_len) ? pat[c] : 1'b1;
            push(tid, 1'b0, 1'b0, 32'h0, r, 1'b0, 1'b1, d0 + 32'(beat), (beat == 7));
            if (r) beat++;
            c++;
        end
        push(tid, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    endfunction

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; req_addr = 32'h0;
        rsp_ready = 1'b0; rsp_ready0 = 1'b0;
        init_wen = 1'b0; init_addr = 32'h0; init_wdata = 32'h0;

        add_burst(1, 32'h0000_0020, 32'h0000_1008, 16'h0000, 0);
        add_burst(2, 32'h0000_0020, 32'h0000_1008, 16'h03E9, 10);
        add_burst(3, 32'h0000_003C, 32'h0000_1008, 16'h0000, 0);
        add_burst(4, 32'h0000_4020, 32'h0000_1008, 16'h0000, 0);
        push(5, 1'b0, 1'b1, 32'h0000_0020, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < LAT; i++) push(5, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int b = 0; b < 3; b++) push(5, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_1008 + 32'(b), 1'b0);
        push(5, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_100B, 1'b0);
        add_burst(5, 32'h0000_0040, 32'h0000_2010, 16'h0000, 0);

        step();
        step();
        check("reset req_ready", 32'(req_ready), 32'h1);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_last", 32'(rsp_last), 32'h0);
        check("reset lat0 req_ready", 32'(req_ready0), 32'h1);
        check("reset lat0 rsp_valid", 32'(rsp_valid0), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) write_word(8 + i, 32'h0000_1000 + 32'(8 + i));
        for (int i = 0; i < 8; i++) write_word(16 + i, 32'h0000_2000 + 32'(16 + i));

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            req_valid = vecs[i].req_valid;
            req_addr  = vecs[i].req_addr;
            rsp_ready = vecs[i].rsp_ready;
            #1;
            check($sformatf("t%0d v%0d req_ready", vecs[i].tid, i), 32'(req_ready), 32'(vecs[i].exp_req_ready));
            check($sformatf("t%0d v%0d rsp_valid", vecs[i].tid, i), 32'(rsp_valid), 32'(vecs[i].exp_rsp_valid));
            check($sformatf("t%0d v%0d rsp_last", vecs[i].tid, i), 32'(rsp_last), 32'(vecs[i].exp_last));
            if (vecs[i].exp_rsp_valid)
                check($sformatf("t%0d v%0d rsp_data", vecs[i].tid, i), rsp_data, vecs[i].exp_data);
            step();
        end
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;

        // Preload write into the word of a held beat: old value this cycle, new value next cycle.
        req_valid = 1'b1; req_addr = 32'h0000_0020;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < LAT; i++) step();
        #1;
        check("hold beat0 valid", 32'(rsp_valid), 32'h1);
        init_wen = 1'b1; init_addr = 32'h0000_0020; init_wdata = 32'hDEAD_BEEF;
        #1;
        check("same-cycle write old data", rsp_data, 32'h0000_1008);
        step();
        init_wen = 1'b0;
        #1;
        check("held beat new data", rsp_data, 32'hDEAD_BEEF);
        check("held beat still valid", 32'(rsp_valid), 32'h1);
        step();
        write_word(8, 32'h0000_1008);
        rsp_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            #1;
            check($sformatf("wr-seq beat%0d data", b), rsp_data, 32'h0000_1008 + 32'(b));
            check($sformatf("wr-seq beat%0d last", b), 32'(rsp_last), 32'(b == 7));
            step();
        end
        check("wr-seq idle req_ready", 32'(req_ready), 32'h1);
        rsp_ready = 1'b0;

        // Zero-latency instance, two requests back-to-back with valid held.
        rsp_ready0 = 1'b1; req_valid0 = 1'b1; req_addr = 32'h0000_0020;
        #1;
        check("lat0 accept req_ready", 32'(req_ready0), 32'h1);
        step();
        req_addr = 32'h0000_0040;
        for (int b = 0; b < 8; b++) begin
            #1;
            check($sformatf("lat0 b1 beat%0d valid", b), 32'(rsp_valid0), 32'h1);
            check($sformatf("lat0 b1 beat%0d req_ready", b), 32'(req_ready0), 32'h0);
            check($sformatf("lat0 b1 beat%0d data", b), rsp_data0, 32'h0000_1008 + 32'(b));
            check($sformatf("lat0 b1 beat%0d last", b), 32'(rsp_last0), 32'(b == 7));
            step();
        end
        #1;
        check("lat0 gap req_ready", 32'(req_ready0), 32'h1);
        check("lat0 gap rsp_valid", 32'(rsp_valid0), 32'h0);
        step();
        req_valid0 = 1'b0;
        for (int b = 0; b < 8; b++) begin
            #1;
            check($sformatf("lat0 b2 beat%0d valid", b), 32'(rsp_valid0), 32'h1);
            check($sformatf("lat0 b2 beat%0d data", b), rsp_data0, 32'h0000_2010 + 32'(b));
            check($sformatf("lat0 b2 beat%0d last", b), 32'(rsp_last0), 32'(b == 7));
            step();
        end
        #1;
        check("lat0 end req_ready", 32'(req_ready0), 32'h1);
        check("lat0 end rsp_valid", 32'(rsp_valid0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
